multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle successor to the single-cycle control decoder. Sequences each RV32I instruction
//  through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared instruction/data memory port.
//  Stalls on a req/ready memory handshake, traps on illegal opcodes and memory timeouts,
//  and counts retired instructions. Sits between the datapath (pc, IR, regfile, ALU) and the unified memory.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles mem_req may stay high without mem_ready before a timeout trap
//  CNT_W        32  width of retire_count (wraps modulo 2**CNT_W)
// PORTS
//  clk              in   1      clock, rising edge
//  reset            in   1      asynchronous, active-high reset
//  instruction      in   32     IR contents, valid from DECODE onward
//  alu_equal        in   1      ALU rs1==rs2 flag, valid in BRANCH
//  mem_ready        in   1      memory completes the pending access this cycle
//  mem_req          out  1      memory access request, held until mem_ready
//  mem_addr_sel     out  1      0 = pc (fetch), 1 = ALU result (data)
//  ir_write         out  1      load IR from memory read data
//  pc_write         out  1      update pc (pc+4 in FETCH, target in BRANCH/JAL)
//  reg_write        out  1      regfile write enable
//  dmem_write       out  1      memory write (stores), qualified by mem_req
//  alu_select       out  1      ALU operand B: 0 = rs2, 1 = immediate
//  result_select    out  1      writeback source: 0 = ALU, 1 = memory data
//  alu_control      out  alu_function_t  ALU operation (cpu_package)
//  instruction_type out  instruction_type_t  decoded format (cpu_package)
//  trap             out  1      sticky: illegal instruction or memory timeout
//  trap_cause       out  1      0 = illegal instruction, 1 = timeout
//  retire_count     out  CNT_W  instructions completed since reset
// BEHAVIOUR
//  Reset (async): state=FETCH, retire_count=0, trap=0, trap_cause=0, timeout counter=0;
//   all outputs except alu_control/instruction_type deassert (those are decode of instruction).
//  States: FETCH, DECODE, EXECUTE, MEM_ADDR, MEM_WAIT, WRITEBACK, BRANCH, JUMP, TRAP.
//  FETCH: mem_req=1, mem_addr_sel=0; on mem_ready: ir_write=1, pc_write=1 (pc+4) -> DECODE.
//  DECODE (1 cycle) by opcode: 0110011 R / 0010011 I-ALU / 0110111 LUI -> EXECUTE;
//   0000011 LOAD / 0100011 STORE -> MEM_ADDR; 1100011 BRANCH -> BRANCH; 1101111 JAL -> JUMP;
//   any other opcode, or BRANCH funct3 not 000/001 -> TRAP, trap_cause=0.
//  EXECUTE: alu_select=1 for I-ALU/LUI -> WRITEBACK.  MEM_ADDR: alu_select=1 -> MEM_WAIT.
//  MEM_WAIT: mem_req=1, mem_addr_sel=1, dmem_write=1 iff STORE; on mem_ready:
//   LOAD -> WRITEBACK (result_select=1); STORE -> FETCH, retire.
//  WRITEBACK: reg_write=1 one cycle, retire -> FETCH.
//  BRANCH: pc_write=1 iff (funct3=000 & alu_equal) | (funct3=001 & !alu_equal); retire -> FETCH.
//  JUMP: pc_write=1, reg_write=1 (rd=pc+4) same cycle; retire -> FETCH.
//  Retire = retire_count+1 on the edge leaving the state; wraps to 0 at 2**CNT_W-1.
//  Timeout: counter clears when mem_req falls or mem_ready=1; increments each cycle
//   mem_req=1 & !mem_ready; reaching MEM_TIMEOUT -> TRAP, trap_cause=1, mem_req drops next cycle.
//  mem_ready while mem_req=0 is ignored. mem_ready and timeout on same cycle: ready wins.
//  TRAP: all enables 0, mem_req=0, trap=1; exits only via reset. No retire on trapping instruction.
//  Latencies with zero-wait memory (mem_ready same cycle as req): R/I/LUI 4, LW 5, SW 4,
//   BEQ/BNE 3, JAL 3 cycles; each wait cycle adds 1 per memory access.
//  Reset mid-instruction: immediate return to FETCH, no partial reg_write/dmem_write after release.
// TESTING
//  instruction=0x0014A303 (lw x6,1(x9)), mem_ready 1st cycle -> 5 cycles FETCH..WB,
//   result_select=1 & reg_write=1 in WB only, retire_count 0->1.
//  Same lw, mem_ready delayed 3 cycles in MEM_WAIT -> mem_req held 3 cycles, 8 cycles total, no trap.
//  0x00208463 (beq x1,x2) alu_equal=1 -> pc_write in BRANCH; alu_equal=0 -> no pc_write, both retire.
//  instruction=0xFFFFFFFF -> TRAP after DECODE, trap=1, trap_cause=0, retire_count unchanged, stays until reset.
//  mem_ready held 0 in FETCH -> trap after exactly MEM_TIMEOUT=16 req cycles, trap_cause=1, mem_req then 0.
//  Assert reset during MEM_WAIT of sw 0x0064A023 -> dmem_write=0 immediately, state FETCH, retire_count=0.

Source files
------------

// File: rtl/cpu_package.sv
// Shared types for the control path: ALU operation codes and decoded instruction formats.
package cpu_package;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluSll,
    AluSlt,
    AluSltu,
    AluXor,
    AluSrl,
    AluSra,
    AluOr,
    AluAnd,
    AluPassB
  } alu_function_t;

  typedef enum logic [2:0] {
    TypeR,
    TypeI,
    TypeS,
    TypeB,
    TypeU,
    TypeJ
  } instruction_type_t;

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: sequences each instruction through fetch, decode, execute,
// memory and writeback over a shared req/ready memory port, with timeout and illegal-op traps.
module multicycle_control
  import cpu_package::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              alu_equal,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_addr_sel,
  output logic              ir_write,
  output logic              pc_write,
  output logic              reg_write,
  output logic              dmem_write,
  output logic              alu_select,
  output logic              result_select,
  output alu_function_t     alu_control,
  output instruction_type_t instruction_type,
  output logic              trap,
  output logic              trap_cause,
  output logic [CNT_W-1:0]  retire_count
);

  localparam int unsigned TmoW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExecute,
    StMemAddr,
    StMemWait,
    StWriteback,
    StBranch,
    StJump,
    StTrap
  } state_e;

  state_e            state_q, state_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic              trap_q, trap_d;
  logic              cause_q, cause_d;
  logic              mem_req_q, mem_req_d;
  logic              addr_sel_q, addr_sel_d;
  logic              dmem_write_q, dmem_write_d;
  logic              alu_select_q, alu_select_d;
  logic              result_select_q, result_select_d;
  logic              reg_write_q, reg_write_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load, is_store, is_imm_alu, is_lui;
  logic       handshake, waiting, tmo_hit, branch_taken;

  assign opcode     = instruction[6:0];
  assign funct3     = instruction[14:12];
  assign is_load    = (opcode == OpLoad);
  assign is_store   = (opcode == OpStore);
  assign is_imm_alu = (opcode == OpImm);
  assign is_lui     = (opcode == OpLui);

  // mem_ready only counts while a request is actually outstanding.
  assign handshake    = mem_req_q & mem_ready;
  assign waiting      = mem_req_q & ~mem_ready;
  assign tmo_hit      = waiting & (tmo_q == TmoW'(MEM_TIMEOUT - 1));
  assign branch_taken = ((funct3 == 3'b000) & alu_equal) | ((funct3 == 3'b001) & ~alu_equal);

  function automatic alu_function_t alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  // Combinational decode of the IR into ALU operation and instruction format.
  always_comb begin
    alu_control      = AluAdd;
    instruction_type = TypeI;
    case (opcode)
      OpR: begin
        instruction_type = TypeR;
        alu_control      = alu_op(funct3, instruction[30]);
      end
      OpImm: begin
        instruction_type = TypeI;
        // Only shifts use bit 30 as a modifier; for addi it is immediate data.
        alu_control      = alu_op(funct3, instruction[30] & (funct3 == 3'b101));
      end
      OpLoad:   instruction_type = TypeI;
      OpStore:  instruction_type = TypeS;
      OpBranch: begin
        instruction_type = TypeB;
        alu_control      = AluSub;
      end
      OpLui: begin
        instruction_type = TypeU;
        alu_control      = AluPassB;
      end
      OpJal:    instruction_type = TypeJ;
      default: begin
        instruction_type = TypeI;
        alu_control      = AluAdd;
      end
    endcase
  end

  // Next state, trap capture, retire counting and the memory timeout counter.
  always_comb begin
    state_d  = state_q;
    trap_d   = trap_q;
    cause_d  = cause_q;
    retire_d = retire_q;
    tmo_d    = waiting ? tmo_q + 1'b1 : '0;
    unique case (state_q)
      StFetch: begin
        if (handshake) begin
          state_d = StDecode;
        end else if (tmo_hit) begin
          state_d = StTrap;
          cause_d = 1'b1;
        end
      end
      StDecode: begin
        case (opcode)
          OpR, OpImm, OpLui: state_d = StExecute;
          OpLoad, OpStore:   state_d = StMemAddr;
          OpJal:             state_d = StJump;
          OpBranch: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
              state_d = StBranch;
            end else begin
              state_d = StTrap;
              cause_d = 1'b0;
            end
          end
          default: begin
            state_d = StTrap;
            cause_d = 1'b0;
          end
        endcase
      end
      StExecute: state_d = StWriteback;
      StMemAddr: state_d = StMemWait;
      StMemWait: begin
        if (handshake) begin
          if (is_store) begin
            state_d  = StFetch;
            retire_d = retire_q + 1'b1;
          end else begin
            state_d = StWriteback;
          end
        end else if (tmo_hit) begin
          state_d = StTrap;
          cause_d = 1'b1;
        end
      end
      StWriteback, StBranch, StJump: begin
        state_d  = StFetch;
        retire_d = retire_q + 1'b1;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
    if (state_d == StTrap) begin
      trap_d = 1'b1;
    end
  end

  // Moore outputs are registered from the upcoming state so they are glitch-free and reset low.
  always_comb begin
    mem_req_d       = (state_d == StFetch) || (state_d == StMemWait);
    addr_sel_d      = (state_d == StMemWait);
    dmem_write_d    = (state_d == StMemWait) && is_store;
    alu_select_d    = ((state_d == StExecute) && (is_imm_alu || is_lui)) || (state_d == StMemAddr);
    result_select_d = (state_d == StWriteback) && is_load;
    reg_write_d     = (state_d == StWriteback) || (state_d == StJump);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StFetch;
      tmo_q           <= '0;
      retire_q        <= '0;
      trap_q          <= 1'b0;
      cause_q         <= 1'b0;
      mem_req_q       <= 1'b0;
      addr_sel_q      <= 1'b0;
      dmem_write_q    <= 1'b0;
      alu_select_q    <= 1'b0;
      result_select_q <= 1'b0;
      reg_write_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmo_q           <= tmo_d;
      retire_q        <= retire_d;
      trap_q          <= trap_d;
      cause_q         <= cause_d;
      mem_req_q       <= mem_req_d;
      addr_sel_q      <= addr_sel_d;
      dmem_write_q    <= dmem_write_d;
      alu_select_q    <= alu_select_d;
      result_select_q <= result_select_d;
      reg_write_q     <= reg_write_d;
    end
  end

  // IR/pc loads depend on same-cycle handshake and branch flag, so they stay combinational.
  always_comb begin
    ir_write = (state_q == StFetch) && handshake;
    pc_write = ir_write || ((state_q == StBranch) && branch_taken) || (state_q == StJump);
  end

  assign mem_req       = mem_req_q;
  assign mem_addr_sel  = addr_sel_q;
  assign dmem_write    = dmem_write_q;
  assign alu_select    = alu_select_q;
  assign result_select = result_select_q;
  assign reg_write     = reg_write_q;
  assign trap          = trap_q;
  assign trap_cause    = cause_q;
  assign retire_count  = retire_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a small req/ready memory responder with configurable
// wait states drives the handshake while per-instruction activity is tallied and checked.
module tb_multicycle_control;
  import cpu_package::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [31:0]       instruction = 32'h0;
  logic              alu_equal = 1'b0;
  logic              mem_ready = 1'b0;
  logic              mem_req, mem_addr_sel, ir_write, pc_write, reg_write, dmem_write;
  logic              alu_select, result_select, trap, trap_cause;
  alu_function_t     alu_control;
  instruction_type_t instruction_type;
  logic [31:0]       retire_count;

  int n_checks = 0;
  int n_fail   = 0;

  int obs_cycles, obs_regw, obs_rsel, obs_pcw, obs_irw, obs_memreq, obs_dmemw;
  logic obs_done;

  multicycle_control #(
    .MEM_TIMEOUT(16),
    .CNT_W      (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .instruction     (instruction),
    .alu_equal       (alu_equal),
    .mem_ready       (mem_ready),
    .mem_req         (mem_req),
    .mem_addr_sel    (mem_addr_sel),
    .ir_write        (ir_write),
    .pc_write        (pc_write),
    .reg_write       (reg_write),
    .dmem_write      (dmem_write),
    .alu_select      (alu_select),
    .result_select   (result_select),
    .alu_control     (alu_control),
    .instruction_type(instruction_type),
    .trap            (trap),
    .trap_cause      (trap_cause),
    .retire_count    (retire_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Runs one instruction until it retires or traps. fw/dw are wait cycles before mem_ready
  // for the fetch and the data access respectively.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int dw, input logic eq);
    logic [31:0] start_cnt;
    int acc, waitc, req_wait, guard;
    instruction = ins;
    alu_equal   = eq;
    start_cnt   = retire_count;
    guard       = 0;
    while (!mem_req && !trap && guard < 4) begin
      step();
      guard++;
    end
    obs_cycles = 0; obs_regw = 0; obs_rsel = 0; obs_pcw = 0;
    obs_irw = 0; obs_memreq = 0; obs_dmemw = 0; obs_done = 1'b0;
    acc = 0;
    waitc = 0;
    for (int n = 1; n <= 60; n++) begin
      req_wait  = (acc == 0) ? fw : dw;
      mem_ready = mem_req && (waitc >= req_wait);
      #1;
      obs_cycles = n;
      if (reg_write) obs_regw++;
      if (reg_write && result_select) obs_rsel++;
      if (pc_write) obs_pcw++;
      if (ir_write) obs_irw++;
      if (mem_req) obs_memreq++;
      if (dmem_write) obs_dmemw++;
      if (mem_req) begin
        if (mem_ready) begin
          acc++;
          waitc = 0;
        end else begin
          waitc++;
        end
      end
      step();
      mem_ready = 1'b0;
      if (retire_count != start_cnt || trap) begin
        obs_done = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    check_eq("rst mem_req", {31'b0, mem_req}, 32'd0);
    check_eq("rst reg_write", {31'b0, reg_write}, 32'd0);
    check_eq("rst dmem_write", {31'b0, dmem_write}, 32'd0);
    check_eq("rst pc_write", {31'b0, pc_write}, 32'd0);
    check_eq("rst trap", {30'b0, trap, trap_cause}, 32'd0);
    check_eq("rst retire", retire_count, 32'd0);

    // lw x6,1(x9), zero-wait memory
    run_instr(32'h0014A303, 0, 0, 1'b0);
    check_eq("lw done", {31'b0, obs_done}, 32'd1);
    check_eq("lw cycles", obs_cycles, 32'd5);
    check_eq("lw reg_write", obs_regw, 32'd1);
    check_eq("lw rsel in wb", obs_rsel, 32'd1);
    check_eq("lw ir/pc write", {obs_irw[15:0], obs_pcw[15:0]}, {16'd1, 16'd1});
    check_eq("lw mem_req cycles", obs_memreq, 32'd2);
    check_eq("lw retire", retire_count, 32'd1);
    check_eq("lw decode", {28'b0, alu_control}, {28'b0, AluAdd});
    check_eq("lw type", {29'b0, instruction_type}, {29'b0, TypeI});

    // Same lw with three data-wait cycles
    run_instr(32'h0014A303, 0, 3, 1'b0);
    check_eq("lw wait cycles", obs_cycles, 32'd8);
    check_eq("lw wait mem_req", obs_memreq, 32'd5);
    check_eq("lw wait no trap", {31'b0, trap}, 32'd0);
    check_eq("lw wait retire", retire_count, 32'd2);

    // beq taken / not taken
    run_instr(32'h00208463, 0, 0, 1'b1);
    check_eq("beq t cycles", obs_cycles, 32'd3);
    check_eq("beq t pc_write", obs_pcw, 32'd2);
    check_eq("beq decode", {28'b0, alu_control}, {28'b0, AluSub});
    check_eq("beq type", {29'b0, instruction_type}, {29'b0, TypeB});
    run_instr(32'h00208463, 0, 0, 1'b0);
    check_eq("beq nt pc_write", obs_pcw, 32'd1);
    check_eq("beq retire", retire_count, 32'd4);

    // R-type add, then decode check of sub
    run_instr(32'h002081B3, 0, 0, 1'b0);
    check_eq("add cycles", obs_cycles, 32'd4);
    check_eq("add wb", {obs_regw[15:0], obs_rsel[15:0]}, {16'd1, 16'd0});
    check_eq("add type", {29'b0, instruction_type}, {29'b0, TypeR});
    instruction = 32'h402081B3;
    #1;
    check_eq("sub decode", {28'b0, alu_control}, {28'b0, AluSub});

    // addi (bit 30 set in the immediate must not turn it into a subtract)
    run_instr(32'h40508093, 0, 0, 1'b0);
    check_eq("addi cycles", obs_cycles, 32'd4);
    check_eq("addi decode", {28'b0, alu_control}, {28'b0, AluAdd});

    // lui
    run_instr(32'h123452B7, 0, 0, 1'b0);
    check_eq("lui cycles", obs_cycles, 32'd4);
    check_eq("lui decode", {25'b0, instruction_type, alu_control},
             {25'b0, TypeU, AluPassB});

    // sw x6,0(x9)
    run_instr(32'h0064A023, 0, 0, 1'b0);
    check_eq("sw cycles", obs_cycles, 32'd4);
    check_eq("sw dmem_write", obs_dmemw, 32'd1);
    check_eq("sw no reg_write", obs_regw, 32'd0);

    // jal x1,8
    run_instr(32'h008000EF, 0, 0, 1'b0);
    check_eq("jal cycles", obs_cycles, 32'd3);
    check_eq("jal reg/pc write", {obs_regw[15:0], obs_pcw[15:0]}, {16'd1, 16'd2});
    check_eq("jal retire", retire_count, 32'd9);

    // Branch with unsupported funct3 traps as illegal
    do_reset();
    run_instr(32'h0020A463, 0, 0, 1'b0);
    check_eq("bad br trap", {30'b0, trap, trap_cause}, 32'b10);
    check_eq("bad br cycles", obs_cycles, 32'd2);

    // Illegal opcode: sticky trap, no retire, no further requests
    do_reset();
    run_instr(32'hFFFFFFFF, 0, 0, 1'b0);
    check_eq("ill trap", {30'b0, trap, trap_cause}, 32'b10);
    check_eq("ill retire", retire_count, 32'd0);
    repeat (5) step();
    check_eq("ill sticky", {30'b0, trap, mem_req}, 32'b10);

    // Fetch timeout: ready never arrives
    do_reset();
    run_instr(32'h002081B3, 1000, 0, 1'b0);
    check_eq("tmo done", {31'b0, obs_done}, 32'd1);
    check_eq("tmo req cycles", obs_memreq, 32'd16);
    check_eq("tmo trap", {30'b0, trap, trap_cause}, 32'b11);
    check_eq("tmo mem_req low", {31'b0, mem_req}, 32'd0);
    check_eq("tmo retire", retire_count, 32'd0);

    // Reset while a store waits for memory
    do_reset();
    instruction = 32'h0064A023;
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (dmem_write) break;
      step();
    end
    check_eq("sw wait dmem/addr", {30'b0, dmem_write, mem_addr_sel}, 32'b11);
    reset = 1'b1;
    #1;
    check_eq("mid rst outputs", {30'b0, dmem_write, mem_req}, 32'd0);
    check_eq("mid rst retire", retire_count, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check_eq("after rst fetch", {29'b0, mem_req, mem_addr_sel, dmem_write}, 32'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
